// File: rtl/led_pattern_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED pattern sequencer:
//   - pattern mode encodings (mode input / registered mode)
//   - controller state enumeration
//   - seed() : start pattern for a given mode and LED count
// No ports; imported by led_pattern_sequencer and button_debounce.
// -----------------------------------------------------------------------------
package led_seq_pkg;

   localparam logic [1:0] MODE_ROL  = 2'b00;
   localparam logic [1:0] MODE_ROR  = 2'b01;
   localparam logic [1:0] MODE_PING = 2'b10;
   localparam logic [1:0] MODE_FILL = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } state_t;

   // Start pattern: MSB for rotate-right so the light enters from the top,
   // LSB for every other mode. Returned 32 bits wide; caller keeps LED_W bits.
   function automatic logic [31:0] seed(input logic [1:0] m, input int unsigned w);
      logic [31:0] s;
      if (m == MODE_ROR) begin
         s = 32'd1 << (w - 32'd1);
      end else begin
         s = 32'd1;
      end
      return s;
   endfunction

endpackage

// File: rtl/led_pattern_sequencer_button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Turns a raw, bouncing, asynchronous push-button into a single-clock press
// pulse: 2-flop synchroniser -> stability debouncer -> rising-edge detect.
// Ports:
//   clk     in  : system clock
//   rst     in  : synchronous active-low reset
//   btn_raw in  : raw button, active-high
//   press   out : registered one-clock pulse per accepted press
// A clean rising edge yields press DEB_MAX+3 clocks later.
// -----------------------------------------------------------------------------
module button_debounce
   import led_seq_pkg::*;
#(
   parameter logic [31:0] DEB_MAX = 32'd1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   logic        sync1_r;
   logic        sync2_r;
   logic        deb_r;
   logic        deb_prev_r;
   logic        press_r;
   logic [31:0] deb_cnt_r;

   // Synchroniser, debounce counter and edge detector
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_r    <= 1'b0;
         sync2_r    <= 1'b0;
         deb_r      <= 1'b0;
         deb_prev_r <= 1'b0;
         press_r    <= 1'b0;
         deb_cnt_r  <= 32'd0;
      end else begin
         sync1_r <= btn_raw;
         sync2_r <= sync1_r;
         // Any return to the accepted level restarts the stability window.
         if (sync2_r == deb_r) begin
            deb_cnt_r <= 32'd0;
         end else if (deb_cnt_r >= (DEB_MAX - 32'd1)) begin
            deb_r     <= ~deb_r;
            deb_cnt_r <= 32'd0;
         end else begin
            deb_cnt_r <= deb_cnt_r + 32'd1;
         end
         deb_prev_r <= deb_r;
         press_r    <= deb_r & ~deb_prev_r;
      end
   end

   assign press = press_r;

endmodule

// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
// Drives an LED_W-bit LED bank with one of four patterns at a selectable rate.
// A debounced button toggles run/pause; the first press starts the sequence.
// Ports:
//   clk     in  : system clock
//   rst     in  : synchronous active-low reset
//   button  in  : raw push-button, active-high
//   mode    in  : 00 rotate left, 01 rotate right, 10 ping-pong, 11 fill
//   speed   in  : step period = CNT_MAX >> speed (minimum 1)
//   led     out : LED drive (registered)
//   running out : high while in RUN (registered)
//   step    out : one-clock pulse whenever led advances or reloads
// -----------------------------------------------------------------------------
module led_pattern_sequencer
   import led_seq_pkg::*;
#(
   parameter int unsigned LED_W   = 8,
   parameter logic [31:0] CNT_MAX = 32'd100_000_000,
   parameter logic [31:0] DEB_MAX = 32'd1_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             button,
   input  logic [1:0]       mode,
   input  logic [1:0]       speed,
   output logic [LED_W-1:0] led,
   output logic             running,
   output logic             step
);

   logic             press_s;
   state_t           state_r;
   state_t           state_nxt_s;
   logic [31:0]      cnt_r;
   logic [31:0]      cnt_nxt_s;
   logic [LED_W-1:0] led_r;
   logic [LED_W-1:0] led_nxt_s;
   logic             dir_r;
   logic             dir_nxt_s;
   logic [1:0]       mode_q_r;
   logic [1:0]       mode_q_nxt_s;
   logic             step_r;
   logic             step_nxt_s;
   logic             running_r;
   logic [31:0]      shifted_s;
   logic [31:0]      period_s;
   logic             wrap_s;
   logic [31:0]      seed_full_s;
   logic [LED_W-1:0] seed_s;
   logic [LED_W-1:0] adv_led_s;
   logic             adv_dir_s;

   button_debounce #(
      .DEB_MAX (DEB_MAX)
   ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (button),
      .press   (press_s)
   );

   // Step period from the speed select; a shift down to zero is clamped to 1
   always_comb begin
      shifted_s = CNT_MAX >> speed;
      if (shifted_s == 32'd0) begin
         period_s = 32'd1;
      end else begin
         period_s = shifted_s;
      end
   end

   // >= rather than == so a speed-up below the current count wraps at once
   assign wrap_s      = (cnt_r >= (period_s - 32'd1));
   assign seed_full_s = seed(mode, LED_W);
   assign seed_s      = seed_full_s[LED_W-1:0];

   // Next pattern value for the registered mode
   always_comb begin
      adv_led_s = led_r;
      adv_dir_s = dir_r;
      case (mode_q_r)
         MODE_ROL: adv_led_s = {led_r[LED_W-2:0], led_r[LED_W-1]};
         MODE_ROR: adv_led_s = {led_r[0], led_r[LED_W-1:1]};
         MODE_PING: begin
            // Direction flips on the step that lands on an end bit, so the
            // end value is never shown twice.
            if (dir_r) begin
               adv_led_s = {led_r[LED_W-2:0], 1'b0};
               adv_dir_s = ~adv_led_s[LED_W-1];
            end else begin
               adv_led_s = {1'b0, led_r[LED_W-1:1]};
               adv_dir_s = adv_led_s[0];
            end
         end
         MODE_FILL: begin
            if (&led_r) begin
               adv_led_s = '0;
            end else begin
               adv_led_s = {led_r[LED_W-2:0], 1'b1};
            end
         end
         default: adv_led_s = led_r;
      endcase
   end

   // Controller next-state: each accepted press moves one state on
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    if (press_s) state_nxt_s = RUN;   else state_nxt_s = IDLE;
         RUN:     if (press_s) state_nxt_s = PAUSE; else state_nxt_s = RUN;
         PAUSE:   if (press_s) state_nxt_s = RUN;   else state_nxt_s = PAUSE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath and output next values; a press outranks a coincident wrap
   always_comb begin
      cnt_nxt_s    = cnt_r;
      led_nxt_s    = led_r;
      dir_nxt_s    = dir_r;
      mode_q_nxt_s = mode_q_r;
      step_nxt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (press_s) begin
               led_nxt_s    = seed_s;
               cnt_nxt_s    = 32'd0;
               dir_nxt_s    = 1'b1;
               mode_q_nxt_s = mode;
               step_nxt_s   = 1'b1;
            end else begin
               step_nxt_s = 1'b0;
            end
         end
         RUN: begin
            if (press_s) begin
               step_nxt_s = 1'b0;
            end else if (wrap_s) begin
               cnt_nxt_s  = 32'd0;
               step_nxt_s = 1'b1;
               if (mode != mode_q_r) begin
                  led_nxt_s    = seed_s;
                  dir_nxt_s    = 1'b1;
                  mode_q_nxt_s = mode;
               end else begin
                  led_nxt_s = adv_led_s;
                  dir_nxt_s = adv_dir_s;
               end
            end else begin
               cnt_nxt_s = cnt_r + 32'd1;
            end
         end
         PAUSE:   step_nxt_s = 1'b0;
         default: step_nxt_s = 1'b0;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= IDLE;
         cnt_r     <= 32'd0;
         led_r     <= '0;
         dir_r     <= 1'b1;
         mode_q_r  <= MODE_ROL;
         step_r    <= 1'b0;
         running_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         led_r     <= led_nxt_s;
         dir_r     <= dir_nxt_s;
         mode_q_r  <= mode_q_nxt_s;
         step_r    <= step_nxt_s;
         running_r <= (state_nxt_s == RUN);
      end
   end

   assign led     = led_r;
   assign running = running_r;
   assign step    = step_r;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_sequencer
// Directed bench for led_pattern_sequencer with LED_W=8, CNT_MAX=4, DEB_MAX=3.
// Inputs change and outputs are sampled on the falling clock edge. A clean
// press raised at negedge N becomes visible on the outputs at negedge N+7.
// -----------------------------------------------------------------------------
module tb_led_pattern_sequencer;

   logic       clk;
   logic       rst;
   logic       button;
   logic [1:0] mode;
   logic [1:0] speed;
   logic [7:0] led;
   logic       running;
   logic       step;

   int errors = 0;
   int checks = 0;

   logic [7:0] rol_tbl  [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
   logic [7:0] ping_tbl [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
   logic [7:0] fill_tbl [10] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00,
                                 8'h01, 8'h03};

   led_pattern_sequencer #(
      .LED_W   (8),
      .CNT_MAX (32'd4),
      .DEB_MAX (32'd3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .button  (button),
      .mode    (mode),
      .speed   (speed),
      .led     (led),
      .running (running),
      .step    (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Clean press: returns on the negedge where the resulting state is visible
   task automatic press_btn();
      button = 1'b1;
      tick(7);
      button = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(1);
      check_eq("rst_led", 32'(led), 32'h0);
      check_eq("rst_running", 32'(running), 32'h0);
      check_eq("rst_step", 32'(step), 32'h0);
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; button = 1'b0; mode = 2'b00; speed = 2'b00;
      @(negedge clk);

      // Rotate left from reset
      do_reset();
      tick(3);
      check_eq("idle_led", 32'(led), 32'h0);
      check_eq("idle_running", 32'(running), 32'h0);
      press_btn();
      check_eq("start_led", 32'(led), 32'h01);
      check_eq("start_running", 32'(running), 32'h1);
      check_eq("start_step", 32'(step), 32'h1);
      for (int k = 0; k < 8; k++) begin
         tick(3);
         check_eq("rol_nostep", 32'(step), 32'h0);
         tick(1);
         check_eq("rol_led", 32'(led), 32'(rol_tbl[k]));
         check_eq("rol_step", 32'(step), 32'h1);
      end

      // Bounce 1-0-1 then held: one press, timed from the final rise
      do_reset();
      button = 1'b1; tick(1);
      button = 1'b0; tick(1);
      button = 1'b1; tick(6);
      check_eq("bounce_led", 32'(led), 32'h0);
      check_eq("bounce_running", 32'(running), 32'h0);
      tick(1);
      check_eq("bounce_press_led", 32'(led), 32'h01);
      check_eq("bounce_press_running", 32'(running), 32'h1);
      button = 1'b0;
      tick(20);
      check_eq("single_press_running", 32'(running), 32'h1);
      check_eq("single_press_led", 32'(led), 32'h20);

      // Ping-pong
      do_reset();
      mode = 2'b10;
      press_btn();
      check_eq("ping_seed", 32'(led), 32'h01);
      for (int k = 0; k < 16; k++) begin
         tick(4);
         check_eq("ping_led", 32'(led), 32'(ping_tbl[k]));
      end

      // Fill, then switch to rotate right mid-run
      do_reset();
      mode = 2'b11;
      press_btn();
      check_eq("fill_seed", 32'(led), 32'h01);
      for (int k = 0; k < 10; k++) begin
         tick(4);
         check_eq("fill_led", 32'(led), 32'(fill_tbl[k]));
      end
      mode = 2'b01;
      tick(4);
      check_eq("mode_switch_seed", 32'(led), 32'h80);
      check_eq("mode_switch_step", 32'(step), 32'h1);
      tick(4);
      check_eq("ror_led", 32'(led), 32'h40);

      // Pause with cnt held at 1, resume, then speed 3 (period 1)
      do_reset();
      mode = 2'b00;
      press_btn();
      check_eq("pause_start", 32'(led), 32'h01);
      tick(7);
      press_btn();
      check_eq("pause_running", 32'(running), 32'h0);
      check_eq("pause_led", 32'(led), 32'h08);
      for (int k = 0; k < 20; k++) begin
         tick(1);
         check_eq("paused_led", 32'(led), 32'h08);
         check_eq("paused_step", 32'(step), 32'h0);
      end
      press_btn();
      check_eq("resume_running", 32'(running), 32'h1);
      check_eq("resume_led", 32'(led), 32'h08);
      tick(2);
      check_eq("resume_wait_led", 32'(led), 32'h08);
      check_eq("resume_wait_step", 32'(step), 32'h0);
      tick(1);
      check_eq("resume_adv_led", 32'(led), 32'h10);
      check_eq("resume_adv_step", 32'(step), 32'h1);
      speed = 2'b11;
      tick(1);
      check_eq("fast_led0", 32'(led), 32'h20);
      tick(1);
      check_eq("fast_led1", 32'(led), 32'h40);
      check_eq("fast_step", 32'(step), 32'h1);
      tick(1);
      check_eq("fast_led2", 32'(led), 32'h80);

      // Reset mid-sequence, then restart from the seed
      do_reset();
      speed = 2'b00;
      tick(2);
      check_eq("post_rst_led", 32'(led), 32'h0);
      press_btn();
      check_eq("restart_led", 32'(led), 32'h01);
      tick(4);
      check_eq("restart_adv", 32'(led), 32'h02);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
